// File: rtl/beeb_bus_slave.sv
// BBC 1MHz bus responder: FRED register strobes, JIM paging registers and a paged FD window onto a req/ack RAM port.
// Latency: one clk50 after the synchronised clke edge; no backpressure beyond the req/ack hold and the sticky overrun flag.
module beeb_bus_slave #(
  parameter logic [7:0] DEVICE_ID = 8'hC8,
  parameter logic [7:0] REG_BASE  = 8'hA0,
  parameter int unsigned OE_HOLD  = 3
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        clke,
  input  logic        rnw,
  input  logic        pgfc_n,
  input  logic        pgfd_n,
  input  logic [7:0]  bus_addr,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  output logic        reg_we,
  output logic [3:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        ram_req,
  output logic        ram_we,
  output logic [18:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic        ram_ack,
  input  logic [7:0]  ram_rdata,
  output logic        overrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RD_HOLD = 2'd2;
  localparam logic [1:0] ST_WR_WAIT = 2'd3;
  localparam int HW = (OE_HOLD < 2) ? 1 : $clog2(OE_HOLD + 1);

  logic [2:0]  clke_sync_q;
  logic [1:0]  rnw_sync_q, fc_sync_q, fd_sync_q;
  logic [7:0]  addr_s1_q, addr_s2_q, din_s1_q, din_s2_q;

  logic [1:0]  state_q, state_d;
  logic [7:0]  page_ctl_q, page_ctl_d, page_mid_q, page_mid_d;
  logic        jim_en_q, jim_en_d;
  logic        late_q, late_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        oe_q, oe_d;
  logic        reg_we_q, reg_we_d;
  logic [3:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        req_q, req_d, we_q, we_d;
  logic [18:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        overrun_q, overrun_d;

  logic        rise_det, fall_det, rnw_s, fc_sel, fd_sel;
  logic        wr_commit, rd_start, fd_write, ack_take, reg_hit;
  logic [7:0]  reg_off;
  logic [18:0] fd_addr;

  assign rise_det  = clke_sync_q[1] & ~clke_sync_q[2];
  assign fall_det  = ~clke_sync_q[1] & clke_sync_q[2];
  assign rnw_s     = rnw_sync_q[1];
  assign fc_sel    = ~fc_sync_q[1];
  assign fd_sel    = ~fd_sync_q[1];
  assign wr_commit = fall_det & ~rnw_s;
  assign rd_start  = rise_det & rnw_s;
  assign fd_write  = wr_commit & fd_sel & jim_en_q;
  assign ack_take  = req_q & ram_ack;
  assign reg_off   = addr_s2_q - REG_BASE;
  assign reg_hit   = (reg_off[7:4] == 4'd0);
  assign fd_addr   = {1'b0, page_ctl_q[1:0], page_mid_q, addr_s2_q};

  always_comb begin
    state_d     = state_q;
    page_ctl_d  = page_ctl_q;
    page_mid_d  = page_mid_q;
    jim_en_d    = jim_en_q;
    late_d      = late_q;
    hold_cnt_d  = hold_cnt_q;
    data_out_d  = data_out_q;
    oe_d        = oe_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    req_d       = req_q;
    we_d        = we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    overrun_d   = overrun_q;

    // FRED writes are handled regardless of any RAM transfer in flight
    if (wr_commit && fc_sel) begin
      if (addr_s2_q == 8'hFF) begin
        page_ctl_d = din_s2_q;
        jim_en_d   = (din_s2_q[7:2] == DEVICE_ID[7:2]);
      end else if (addr_s2_q == 8'hFE) begin
        page_mid_d = din_s2_q;
      end else if (reg_hit) begin
        reg_we_d    = 1'b1;
        reg_addr_d  = reg_off[3:0];
        reg_wdata_d = din_s2_q;
      end
    end

    if (fd_write && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fd_write) begin
          state_d     = ST_WR_WAIT;
          req_d       = 1'b1;
          we_d        = 1'b1;
          ram_addr_d  = fd_addr;
          ram_wdata_d = din_s2_q;
        end else if (rd_start && fc_sel && (addr_s2_q[7:1] == 7'h7F)) begin
          data_out_d = addr_s2_q[0] ? page_ctl_q : page_mid_q;
          oe_d       = 1'b1;
          state_d    = ST_RD_HOLD;
        end else if (rd_start && fd_sel && jim_en_q) begin
          state_d    = ST_RD_WAIT;
          req_d      = 1'b1;
          we_d       = 1'b0;
          ram_addr_d = fd_addr;
          oe_d       = 1'b1;
          late_d     = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        // A read acked after the bus cycle ended is completed but its data discarded
        if (ack_take) begin
          req_d = 1'b0;
          if (late_q) begin
            state_d = ST_IDLE;
          end else begin
            data_out_d = ram_rdata;
            state_d    = ST_RD_HOLD;
          end
        end else if (fall_det) begin
          overrun_d = 1'b1;
          late_d    = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (ack_take) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
      if (hold_cnt_q == HW'(1)) begin
        oe_d = 1'b0;
        if (state_q == ST_RD_HOLD) state_d = ST_IDLE;
      end
    end else if (fall_det && oe_q) begin
      if (OE_HOLD == 0) begin
        oe_d = 1'b0;
        if (state_q == ST_RD_HOLD) state_d = ST_IDLE;
      end else begin
        hold_cnt_d = HW'(OE_HOLD);
      end
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      clke_sync_q <= '0;
      rnw_sync_q  <= '0;
      fc_sync_q   <= '1;
      fd_sync_q   <= '1;
      addr_s1_q   <= '0;
      addr_s2_q   <= '0;
      din_s1_q    <= '0;
      din_s2_q    <= '0;
      state_q     <= ST_IDLE;
      page_ctl_q  <= '0;
      page_mid_q  <= '0;
      jim_en_q    <= 1'b0;
      late_q      <= 1'b0;
      hold_cnt_q  <= '0;
      data_out_q  <= '0;
      oe_q        <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      clke_sync_q <= {clke_sync_q[1:0], clke};
      rnw_sync_q  <= {rnw_sync_q[0], rnw};
      fc_sync_q   <= {fc_sync_q[0], pgfc_n};
      fd_sync_q   <= {fd_sync_q[0], pgfd_n};
      addr_s1_q   <= bus_addr;
      addr_s2_q   <= addr_s1_q;
      din_s1_q    <= bus_data_in;
      din_s2_q    <= din_s1_q;
      state_q     <= state_d;
      page_ctl_q  <= page_ctl_d;
      page_mid_q  <= page_mid_d;
      jim_en_q    <= jim_en_d;
      late_q      <= late_d;
      hold_cnt_q  <= hold_cnt_d;
      data_out_q  <= data_out_d;
      oe_q        <= oe_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      req_q       <= req_d;
      we_q        <= we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus_data_out = data_out_q;
  assign bus_data_oe  = oe_q;
  assign reg_we       = reg_we_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign ram_req      = req_q;
  assign ram_we       = we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign overrun      = overrun_q;

endmodule
